// File: rtl/alu_pkg.sv
// Purpose: ALU op encoding, op width and op-to-instruction decode shared by the ALU and its arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: alu_op_t, OP_W, alu_instr_t, to_instr().
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_ADDI = 3'd2,
    OP_BEQ  = 3'd3,
    OP_JAL  = 3'd4
  } alu_op_t;

  // Decoded control word consumed by the ALU datapath.
  typedef struct packed {
    logic valid;      // op does real work (not a bubble)
    logic use_imm;    // second operand is imm instead of rs2
    logic is_branch;  // result is a conditional branch target
    logic is_jump;    // result is an unconditional jump target
  } alu_instr_t;

  function automatic alu_instr_t to_instr(alu_op_t op);
    alu_instr_t ins;
    ins = '0;
    case (op)
      OP_ADD:  ins.valid = 1'b1;
      OP_ADDI: begin ins.valid = 1'b1; ins.use_imm = 1'b1; end
      OP_BEQ:  begin ins.valid = 1'b1; ins.use_imm = 1'b1; ins.is_branch = 1'b1; end
      OP_JAL:  begin ins.valid = 1'b1; ins.use_imm = 1'b1; ins.is_jump = 1'b1; end
      default: ins = '0;
    endcase
    return ins;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter, one-hot grant plus index; search starts just after the last winner.
// Latency: grant is combinational from req_i; pointer moves at the edge where advance_i is high.
// Backpressure: none internally; the caller decides via advance_i whether a grant was consumed.
// Ports: clk_i, rstn_i (async active-low), req_i[N], advance_i -> gnt_o[N] one-hot, idx_o[$clog2(N)].
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);
  // One extra bit so last+offset never overflows before the single wrap subtraction.
  localparam int CW = IW + 1;

  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, last_q} + CW'(k + 1);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IW-1:0]]   = 1'b1;
        idx_o                 = cand[IW-1:0];
      end
    end
  end

  assign last_d = advance_i ? idx_o : last_q;

  // Reset to N-1 so requester 0 is scanned first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_q <= IW'(N - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one registered-result ALU between N_REQ requesters with round-robin grant.
// Latency: accept (req_valid&req_ready) in cycle N -> rsp_valid in cycle N+2.
// Backpressure: a requester with an op in flight or an unconsumed response is not granted.
// Ports: clk_i, rstn_i; req_{valid,op,rs1_v,rs2_v,imm}_i / req_ready_o per requester;
//        alu_{op,rs1_v,rs2_v,imm}_o to ALU, alu_result_i back; rsp_{valid,data}_o / rsp_ready_i.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  alu_op_t [N_REQ-1:0]    req_op_i,
  input  logic [N_REQ-1:0][31:0] req_rs1_v_i,
  input  logic [N_REQ-1:0][31:0] req_rs2_v_i,
  input  logic [N_REQ-1:0][31:0] req_imm_i,
  output alu_op_t                alu_op_o,
  output logic [31:0]            alu_rs1_v_o,
  output logic [31:0]            alu_rs2_v_o,
  output logic [31:0]            alu_imm_o,
  input  logic [31:0]            alu_result_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [N_REQ-1:0][31:0] rsp_data_o
);

  localparam int TAG_W = $clog2(N_REQ);

  logic                   inflight_v_q, inflight_v_d;
  logic [TAG_W-1:0]       inflight_tag_q, inflight_tag_d;
  logic [N_REQ-1:0]       rsp_full_q, rsp_full_d;
  logic [N_REQ-1:0][31:0] rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]       elig;
  logic [N_REQ-1:0]       gnt;
  logic [TAG_W-1:0]       gnt_idx;
  logic                   gnt_any;

  // A requester may have only one op outstanding: either in the ALU or parked in its buffer.
  // A pop this cycle does not make the requester eligible until the next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid_i[i] & ~rsp_full_q[i]
              & ~(inflight_v_q && (inflight_tag_q == TAG_W'(i)));
    end
  end

  assign gnt_any = |elig;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (elig),
    .advance_i (gnt_any),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );

  assign req_ready_o = gnt;

  // Operand mux; bubbles are driven as NOP with zero operands.
  always_comb begin
    alu_op_o    = OP_NOP;
    alu_rs1_v_o = '0;
    alu_rs2_v_o = '0;
    alu_imm_o   = '0;
    if (gnt_any) begin
      alu_op_o    = req_op_i[gnt_idx];
      alu_rs1_v_o = req_rs1_v_i[gnt_idx];
      alu_rs2_v_o = req_rs2_v_i[gnt_idx];
      alu_imm_o   = req_imm_i[gnt_idx];
    end
  end

  // Write into a buffer and pop of the same buffer never coincide: the write targets a
  // requester that was empty when granted, and it stays blocked until the write lands.
  always_comb begin
    inflight_v_d   = gnt_any;
    inflight_tag_d = gnt_any ? gnt_idx : inflight_tag_q;
    rsp_full_d     = rsp_full_q & ~rsp_ready_i;
    rsp_data_d     = rsp_data_q;
    if (inflight_v_q) begin
      rsp_full_d[inflight_tag_q] = 1'b1;
      rsp_data_d[inflight_tag_q] = alu_result_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_v_q   <= 1'b0;
      inflight_tag_q <= '0;
      rsp_full_q     <= '0;
      rsp_data_q     <= '0;
    end else begin
      inflight_v_q   <= inflight_v_d;
      inflight_tag_q <= inflight_tag_d;
      rsp_full_q     <= rsp_full_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_full_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter with a stand-in registered ALU and an ownership model.
// Latency: expects responses two cycles after acceptance.
// Backpressure: exercises held responses, alternating requesters, idle and async reset mid-op.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NR = 2;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready;
  alu_op_t [NR-1:0]    req_op = '{default: OP_NOP};
  logic [NR-1:0][31:0] req_rs1 = '0;
  logic [NR-1:0][31:0] req_rs2 = '0;
  logic [NR-1:0][31:0] req_imm = '0;
  alu_op_t             alu_op;
  logic [31:0]         alu_rs1, alu_rs2, alu_imm;
  logic [31:0]         alu_result = '0;
  logic [NR-1:0]       rsp_valid;
  logic [NR-1:0]       rsp_ready = '0;
  logic [NR-1:0][31:0] rsp_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state: a requester "owns" the ALU path from acceptance until its response is taken.
  bit          owned   [NR];
  int          gcyc    [NR];
  logic [31:0] edata   [NR];
  int          last;

  // Values sampled by the most recent cycle, for directed checks.
  logic [NR-1:0]       obs_ready, obs_valid;
  logic [NR-1:0][31:0] obs_data;

  alu_arbiter #(.N_REQ(NR)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_rs1_v_i  (req_rs1),
    .req_rs2_v_i  (req_rs2),
    .req_imm_i    (req_imm),
    .alu_op_o     (alu_op),
    .alu_rs1_v_o  (alu_rs1),
    .alu_rs2_v_o  (alu_rs2),
    .alu_imm_o    (alu_imm),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(alu_op_t op, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    case (op)
      OP_ADD:                  return a + b;
      OP_ADDI, OP_BEQ, OP_JAL: return a + imm;
      default:                 return 32'h0;
    endcase
  endfunction

  // Stand-in ALU: result registered one cycle after operands.
  always @(posedge clk) alu_result <= alu_fn(alu_op, alu_rs1, alu_rs2, alu_imm);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      owned[i] = 1'b0;
      gcyc[i]  = 0;
      edata[i] = '0;
    end
    last = NR - 1;
  endtask

  // Called at the falling edge: check what the DUT shows against the model, then advance the model
  // by the handshakes that will happen at the next rising edge.
  task automatic model_step();
    int            g;
    int            c;
    logic [NR-1:0] er, ev;
    g = -1;
    for (int k = 1; k <= NR; k++) begin
      c = (last + k) % NR;
      if (g < 0 && req_valid[c] && !owned[c]) g = c;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (g >= 0) begin
      chk("alu_op",  32'(alu_op), 32'(req_op[g]));
      chk("alu_rs1", alu_rs1, req_rs1[g]);
      chk("alu_rs2", alu_rs2, req_rs2[g]);
      chk("alu_imm", alu_imm, req_imm[g]);
    end else begin
      chk("idle_op",  32'(alu_op), 32'(OP_NOP));
      chk("idle_opnd", alu_rs1 | alu_rs2 | alu_imm, 32'h0);
    end
    ev = '0;
    for (int i = 0; i < NR; i++) ev[i] = owned[i] && (cyc >= gcyc[i] + 2);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    for (int i = 0; i < NR; i++) if (ev[i]) chk("rsp_data", rsp_data[i], edata[i]);

    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_data  = rsp_data;

    for (int i = 0; i < NR; i++) if (ev[i] && rsp_ready[i]) owned[i] = 1'b0;
    if (g >= 0) begin
      owned[g] = 1'b1;
      gcyc[g]  = cyc;
      edata[g] = alu_fn(req_op[g], req_rs1[g], req_rs2[g], req_imm[g]);
      last     = g;
    end
    cyc++;
  endtask

  // Inputs are set by the caller just after a rising edge; this samples at the falling edge
  // and returns 1 time unit after the following rising edge.
  task automatic run_cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    model_reset();
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data0", rsp_data[0], 32'h0);
    chk("rst_data1", rsp_data[1], 32'h0);
    chk("rst_op",    32'(alu_op), 32'(OP_NOP));
    chk("rst_opnd",  alu_rs1 | alu_rs2 | alu_imm, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input alu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_rs1[i]   = a;
    req_rs2[i]   = b;
    req_imm[i]   = imm;
  endtask

  task automatic rand_req(input int i);
    drive(i, alu_op_t'($urandom_range(0, 4)), $urandom, $urandom, $urandom);
    req_valid[i] = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset with an op accepted the previous cycle: its response must never appear.
    drive(0, OP_ADD, 32'd1, 32'd2, 32'd0);
    run_cycle();
    chk("midop_grant", 32'(obs_ready), 32'h1);
    do_reset();
    rsp_ready = '1;
    repeat (4) run_cycle();
    chk("midop_novalid", 32'(obs_valid), 32'h0);

    // Single ADD 5+7.
    drive(0, OP_ADD, 32'd5, 32'd7, 32'd0);
    run_cycle();
    chk("single_grant", 32'(obs_ready), 32'h1);
    req_valid = '0;
    run_cycle();
    chk("single_n1", 32'(obs_valid), 32'h0);
    run_cycle();
    chk("single_n2", 32'(obs_valid), 32'h1);
    chk("single_data", obs_data[0], 32'd12);
    repeat (2) run_cycle();

    // Wrap and target ops.
    drive(0, OP_ADDI, 32'hFFFF_FFFF, 32'h0, 32'd1);
    run_cycle();
    req_valid = '0;
    repeat (2) run_cycle();
    chk("wrap_data", obs_data[0], 32'h0);
    drive(1, OP_BEQ, 32'h0000_1000, 32'h0, 32'h0000_0020);
    run_cycle();
    req_valid = '0;
    repeat (2) run_cycle();
    chk("beq_data", obs_data[1], 32'h0000_1020);
    drive(0, OP_JAL, 32'h8000_0000, 32'h5, 32'h0000_0444);
    run_cycle();
    req_valid = '0;
    repeat (2) run_cycle();
    chk("jal_data", obs_data[0], 32'h8000_0444);
    repeat (2) run_cycle();

    // Contention from reset: requester 0 wins first, then grants alternate.
    do_reset();
    rsp_ready = '1;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NR; i++) drive(i, OP_ADDI, $urandom, $urandom, 32'd1);
      run_cycle();
      if (n == 0) chk("cont_first", 32'(obs_ready), 32'h1);
      if (n == 1) chk("cont_second", 32'(obs_ready), 32'h2);
    end

    // Backpressure on requester 0.
    rsp_ready = 2'b10;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NR; i++) drive(i, OP_ADD, $urandom, $urandom, $urandom);
      run_cycle();
    end
    chk("bp_held", 32'(obs_valid[0]), 32'h1);
    rsp_ready = '1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NR; i++) drive(i, OP_ADD, $urandom, $urandom, $urandom);
      run_cycle();
    end

    // Idle.
    req_valid = '0;
    repeat (12) run_cycle();
    chk("idle_novalid", 32'(obs_valid), 32'h0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) rand_req(i);
      rsp_ready = NR'($urandom);
      if (n % 700 == 699) do_reset();
      else                run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
